// File: rtl/cache_traffic_gen.sv
// cache_traffic_gen: drives the processor-side port of cache_memory with
// sequential, strided, LFSR-random or write-then-verify access patterns and
// accumulates hit/miss/access/mismatch statistics for on-chip profiling.
module cache_traffic_gen #(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter int          CNT_WIDTH  = 16,
  parameter int          TIMEOUT    = 64,
  parameter logic [31:0] LFSR_SEED  = 32'h1ACE_B00C
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] stride,
  input  logic [ADDR_WIDTH-1:0] addr_mask,
  input  logic [CNT_WIDTH-1:0]  count,
  input  logic [DATA_WIDTH-1:0] data_seed,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  read_enable,
  output logic                  write_enable,
  output logic [DATA_WIDTH-1:0] write_data,
  input  logic [DATA_WIDTH-1:0] read_data,
  input  logic                  hit,
  input  logic                  miss,
  input  logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  miss_count,
  output logic [CNT_WIDTH-1:0]  access_count,
  output logic [CNT_WIDTH-1:0]  mismatch_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} fsmState_t;

  localparam int                  WaitW    = $clog2(TIMEOUT + 1);
  localparam logic [31:0]         LfsrPoly = 32'h8020_0003;
  localparam logic [CNT_WIDTH-1:0] CntMax  = '1;

  fsmState_t             state_q;
  logic [1:0]            mode_q;
  logic [ADDR_WIDTH-1:0] base_q, stride_q, mask_q;
  logic [CNT_WIDTH-1:0]  count_q;
  logic [DATA_WIDTH-1:0] seed_q;
  logic [CNT_WIDTH-1:0]  stepIdx_q;
  logic                  isRead_q;
  logic [31:0]           lfsr_q;
  logic [WaitW-1:0]      waitCnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  readEn_q, writeEn_q;
  logic [DATA_WIDTH-1:0] writeData_q;
  logic                  busy_q, done_q, timeoutErr_q;
  logic [CNT_WIDTH-1:0]  hitCnt_q, missCnt_q, accessCnt_q, mismatchCnt_q;

  logic [ADDR_WIDTH-1:0] issueAddr_d;
  logic [DATA_WIDTH-1:0] stepData;
  logic [CNT_WIDTH-1:0]  stepNext;
  logic [31:0]           lfsr_d;

  // Saturating increment shared by all statistic counters.
  function automatic logic [CNT_WIDTH-1:0] satInc(input logic [CNT_WIDTH-1:0] v);
    return (v == CntMax) ? v : v + CNT_WIDTH'(1);
  endfunction

  // Address, data and LFSR successor for the current step of the latched pattern.
  always_comb begin
    lfsr_d   = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LfsrPoly : 32'h0);
    stepData = seed_q + DATA_WIDTH'(stepIdx_q);
    stepNext = stepIdx_q + CNT_WIDTH'(1);
    issueAddr_d = base_q + (ADDR_WIDTH'(stepIdx_q) << 2);
    case (mode_q)
      2'd1:    issueAddr_d = base_q + stride_q * ADDR_WIDTH'(stepIdx_q);
      2'd2:    issueAddr_d = base_q + (ADDR_WIDTH'(lfsr_q) & mask_q & ~ADDR_WIDTH'(3));
      default: issueAddr_d = base_q + (ADDR_WIDTH'(stepIdx_q) << 2);
    endcase
  end

  // Run-control FSM; every cache-facing and status output is registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      mode_q        <= 2'd0;
      base_q        <= '0;
      stride_q      <= '0;
      mask_q        <= '0;
      count_q       <= '0;
      seed_q        <= '0;
      stepIdx_q     <= '0;
      isRead_q      <= 1'b0;
      lfsr_q        <= LFSR_SEED;
      waitCnt_q     <= '0;
      addr_q        <= '0;
      readEn_q      <= 1'b0;
      writeEn_q     <= 1'b0;
      writeData_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeoutErr_q  <= 1'b0;
      hitCnt_q      <= '0;
      missCnt_q     <= '0;
      accessCnt_q   <= '0;
      mismatchCnt_q <= '0;
    end else begin
      readEn_q  <= 1'b0;
      writeEn_q <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mode_q        <= mode;
            base_q        <= base_addr;
            stride_q      <= stride;
            mask_q        <= addr_mask;
            count_q       <= count;
            seed_q        <= data_seed;
            stepIdx_q     <= '0;
            isRead_q      <= 1'b0;
            lfsr_q        <= LFSR_SEED;
            timeoutErr_q  <= 1'b0;
            hitCnt_q      <= '0;
            missCnt_q     <= '0;
            accessCnt_q   <= '0;
            mismatchCnt_q <= '0;
            if (count == '0) begin
              state_q <= DONE;
            end else begin
              state_q <= ISSUE;
              busy_q  <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (ready) begin
            addr_q    <= issueAddr_d;
            waitCnt_q <= '0;
            state_q   <= WAIT;
            if (mode_q == 2'd3 && !isRead_q) begin
              writeEn_q   <= 1'b1;
              writeData_q <= stepData;
            end else begin
              readEn_q <= 1'b1;
            end
            if (mode_q == 2'd2) begin
              lfsr_q <= lfsr_d;
            end
          end
        end
        WAIT: begin
          if (waitCnt_q == '0) begin
            waitCnt_q <= WaitW'(1);
          end else if (hit || miss) begin
            accessCnt_q <= satInc(accessCnt_q);
            if (hit) begin
              hitCnt_q <= satInc(hitCnt_q);
            end else begin
              missCnt_q <= satInc(missCnt_q);
            end
            if (mode_q == 2'd3 && isRead_q && hit && read_data != stepData) begin
              mismatchCnt_q <= satInc(mismatchCnt_q);
            end
            if (mode_q == 2'd3 && !isRead_q) begin
              isRead_q <= 1'b1;
              state_q  <= ISSUE;
            end else begin
              isRead_q  <= 1'b0;
              stepIdx_q <= stepNext;
              if (stepNext == count_q) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
              end else begin
                state_q <= ISSUE;
              end
            end
          end else if (waitCnt_q == WaitW'(TIMEOUT)) begin
            timeoutErr_q <= 1'b1;
            state_q      <= DONE;
            busy_q       <= 1'b0;
          end else begin
            waitCnt_q <= waitCnt_q + WaitW'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign addr           = addr_q;
  assign read_enable    = readEn_q;
  assign write_enable   = writeEn_q;
  assign write_data     = writeData_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign timeout_err    = timeoutErr_q;
  assign hit_count      = hitCnt_q;
  assign miss_count     = missCnt_q;
  assign access_count   = accessCnt_q;
  assign mismatch_count = mismatchCnt_q;

endmodule
